// File: rtl/test_monitor.sv
// End-of-test monitor for a CPU test harness.
// Snoops data-memory writes for an end-of-test marker byte, then scans the
// result area word by word against a golden table. It reports pass/fail, the
// error count and the first failing index. A timeout is flagged if the
// marker never arrives.
module test_monitor #(
  parameter int          ADDR_W       = 16,
  parameter logic [31:0] ANSWER_START = 32'h9000,
  parameter int          NUM_WORDS    = 64,
  parameter logic [31:0] DONE_ADDR    = 32'hfffc,
  parameter logic [7:0]  DONE_BYTE    = 8'hff,
  parameter int          MAX_CYCLES   = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              scan_en,
  output logic [ADDR_W-1:0] scan_addr,
  input  logic [31:0]       scan_rdata,
  output logic [7:0]        gold_idx,
  input  logic [31:0]       gold_rdata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [8:0]        err_count,
  output logic [7:0]        first_err_idx,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    FIN   = 3'd3,
    TMO   = 3'd4
  } state_t;

  localparam logic [7:0]        LAST_IDX  = 8'(NUM_WORDS - 1);
  localparam logic [31:0]       TMO_LAST  = 32'(MAX_CYCLES - 1);
  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(ANSWER_START);
  localparam logic [ADDR_W-1:0] DONE_A    = ADDR_W'(DONE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);
  localparam logic [8:0]        ERR_MAX   = 9'h1ff;

  state_t      state;
  logic        cmp_valid;   // read data for cmp_idx is on the buses this cycle
  logic [7:0]  cmp_idx;
  logic        marker;
  logic        mismatch;
  logic [8:0]  err_next;
  logic        unused_bits;

  // Only byte lane 0 carries the marker; the other lanes are intentionally ignored.
  assign unused_bits = ^{dm_we[3:1], dm_wdata[31:8]};

  assign marker = (state == RUN) && dm_we[0] && (dm_addr == DONE_A) &&
                  (dm_wdata[7:0] == DONE_BYTE);

  // Compare the word returned for the previous issue and form the next error count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    mismatch = 1'b0;
    err_next = err_count;
    if (cmp_valid && (scan_rdata != gold_rdata)) begin
      mismatch = 1'b1;
      if (err_count != ERR_MAX) err_next = err_count + 9'd1;
    end
  end

  // Monitor state machine; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      state         <= RUN;
      cmp_valid     <= 1'b0;
      cmp_idx       <= '0;
      scan_en       <= 1'b0;
      scan_addr     <= '0;
      gold_idx      <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      cycle_count   <= '0;
    end else if (clear) begin
      state         <= RUN;
      cmp_valid     <= 1'b0;
      cmp_idx       <= '0;
      scan_en       <= 1'b0;
      scan_addr     <= '0;
      gold_idx      <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      cycle_count   <= '0;
    end else begin
      // Read data lags the issue by one cycle, so the index is delayed to match.
      cmp_valid <= scan_en;
      cmp_idx   <= gold_idx;
      err_count <= err_next;
      if (mismatch && (err_count == 9'd0)) first_err_idx <= cmp_idx;

      unique case (state)
        RUN: begin
          if (marker) begin
            // The marker wins over a coincident timeout.
            state     <= SCAN;
            scan_en   <= 1'b1;
            scan_addr <= START_A;
            gold_idx  <= 8'd0;
          end else if (cycle_count == TMO_LAST) begin
            state   <= TMO;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else if (cycle_count != 32'hffff_ffff) begin
            cycle_count <= cycle_count + 32'd1;
          end
        end
        SCAN: begin
          if (gold_idx == LAST_IDX) begin
            state     <= DRAIN;
            scan_en   <= 1'b0;
            scan_addr <= '0;
            gold_idx  <= 8'd0;
          end else begin
            scan_addr <= scan_addr + ADDR_STEP;
            gold_idx  <= gold_idx + 8'd1;
          end
        end
        DRAIN: begin
          // The last comparison lands in this cycle, so judge on err_next.
          state <= FIN;
          done  <= 1'b1;
          pass  <= (err_next == 9'd0);
          fail  <= (err_next != 9'd0);
        end
        FIN, TMO: begin
          state <= state;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: a vector table for marker detection plus
// hand-written sequences for scan, mismatch, timeout, reset and clear.
module tb_test_monitor;

  localparam int N    = 4;
  localparam int MAXC = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [3:0]  dm_we;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        scan_en;
  logic [15:0] scan_addr;
  logic [31:0] scan_rdata;
  logic [7:0]  gold_idx;
  logic [31:0] gold_rdata;
  logic        done, pass, fail, timeout;
  logic [8:0]  err_count;
  logic [7:0]  first_err_idx;
  logic [31:0] cycle_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [N];
  logic [31:0] gold [N];

  test_monitor #(
    .ADDR_W      (16),
    .ANSWER_START(32'h9000),
    .NUM_WORDS   (N),
    .DONE_ADDR   (32'hfffc),
    .DONE_BYTE   (8'hff),
    .MAX_CYCLES  (MAXC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .dm_we        (dm_we),
    .dm_addr      (dm_addr),
    .dm_wdata     (dm_wdata),
    .scan_en      (scan_en),
    .scan_addr    (scan_addr),
    .scan_rdata   (scan_rdata),
    .gold_idx     (gold_idx),
    .gold_rdata   (gold_rdata),
    .done         (done),
    .pass         (pass),
    .fail         (fail),
    .timeout      (timeout),
    .err_count    (err_count),
    .first_err_idx(first_err_idx),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  // Result-area memory model: only word-aligned addresses inside the answer block return data.
  function automatic logic [31:0] mem_read(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h9000;
    if (off < 16'(4 * N) && off[1:0] == 2'b00) return mem[off[3:2]];
    return 32'hdead_beef;
  endfunction

  // One-cycle read latency for both data and golden tables; idle values differ on purpose.
  always @(posedge clk) begin
    if (scan_en) begin
      scan_rdata <= mem_read(scan_addr);
      gold_rdata <= (gold_idx < 8'(N)) ? gold[gold_idx[1:0]] : 32'h0bad_0bad;
    end else begin
      scan_rdata <= 32'ha5a5_a5a5;
      gold_rdata <= 32'h5a5a_5a5a;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_bus();
    dm_we    = 4'd0;
    dm_addr  = 16'd0;
    dm_wdata = 32'd0;
  endtask

  // Present the marker write for one cycle (cycle t0); returns at t0+1.
  task automatic marker_cycle();
    dm_we    = 4'b0001;
    dm_addr  = 16'hfffc;
    dm_wdata = 32'h0000_00ff;
    tick();
    idle_bus();
  endtask

  // Called at t0+1: checks the issue sequence, drain cycle and final verdict.
  task automatic run_scan(input string tag, input int exp_err, input int exp_first);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s scan_en[%0d]", tag, i), 32'(scan_en), 32'd1);
      check($sformatf("%s scan_addr[%0d]", tag, i), 32'(scan_addr), 32'h9000 + 32'(4 * i));
      check($sformatf("%s gold_idx[%0d]", tag, i), 32'(gold_idx), 32'(i));
      check($sformatf("%s done_early[%0d]", tag, i), 32'(done), 32'd0);
      // A second marker during the scan must be ignored.
      if (i == 1) begin
        dm_we = 4'b0001; dm_addr = 16'hfffc; dm_wdata = 32'hff;
      end else begin
        idle_bus();
      end
      tick();
    end
    idle_bus();
    check({tag, " drain scan_en"}, 32'(scan_en), 32'd0);
    check({tag, " drain scan_addr"}, 32'(scan_addr), 32'd0);
    check({tag, " drain gold_idx"}, 32'(gold_idx), 32'd0);
    check({tag, " drain done"}, 32'(done), 32'd0);
    tick();
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " pass"}, 32'(pass), (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, " fail"}, 32'(fail), (exp_err != 0) ? 32'd1 : 32'd0);
    check({tag, " timeout"}, 32'(timeout), 32'd0);
    check({tag, " err_count"}, 32'(err_count), 32'(exp_err));
    check({tag, " first_err_idx"}, 32'(first_err_idx), 32'(exp_first));
    check({tag, " scan_en fin"}, 32'(scan_en), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        clr;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        exp_scan;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"marker lane0",      1'b0, 4'b0001, 16'hfffc, 32'h0000_00ff, 1'b1};
    vecs[1] = '{"ff on lane1",       1'b0, 4'b0010, 16'hfffc, 32'h0000_00ff, 1'b0};
    vecs[2] = '{"ff in lane1 data",  1'b0, 4'b0010, 16'hfffc, 32'h0000_ff00, 1'b0};
    vecs[3] = '{"fe on lane0",       1'b0, 4'b0001, 16'hfffc, 32'h0000_00fe, 1'b0};
    vecs[4] = '{"wrong address",     1'b0, 4'b0001, 16'hfff8, 32'h0000_00ff, 1'b0};
    vecs[5] = '{"full word write",   1'b0, 4'b1111, 16'hfffc, 32'h1234_56ff, 1'b1};
    vecs[6] = '{"no strobe",         1'b0, 4'b0000, 16'hfffc, 32'h0000_00ff, 1'b0};
    vecs[7] = '{"clear beats marker", 1'b1, 4'b0001, 16'hfffc, 32'h0000_00ff, 1'b0};

    for (int i = 0; i < N; i++) begin
      mem[i]  = 32'h1000_0000 + 32'(i * 32'h0101_0101);
      gold[i] = 32'h1000_0000 + 32'(i * 32'h0101_0101);
    end
    clear = 1'b0;
    idle_bus();
    rst = 1'b1;
    #12;

    // Reset values while rst is held.
    check("rst done", 32'(done), 32'd0);
    check("rst pass", 32'(pass), 32'd0);
    check("rst fail", 32'(fail), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    check("rst scan_en", 32'(scan_en), 32'd0);
    check("rst scan_addr", 32'(scan_addr), 32'd0);
    check("rst gold_idx", 32'(gold_idx), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst first_err_idx", 32'(first_err_idx), 32'd0);
    check("rst cycle_count", 32'(cycle_count), 32'd0);
    do_reset();

    // Marker detection table: each vector starts from a freshly cleared RUN state.
    for (int v = 0; v < 8; v++) begin
      clear = 1'b1;
      tick();
      clear    = vecs[v].clr;
      dm_we    = vecs[v].we;
      dm_addr  = vecs[v].addr;
      dm_wdata = vecs[v].wdata;
      tick();
      clear = 1'b0;
      idle_bus();
      check({vecs[v].name, " scan_en"}, 32'(scan_en), 32'(vecs[v].exp_scan));
      check({vecs[v].name, " done"}, 32'(done), 32'd0);
    end

    // Clean scan: memory equals golden.
    do_reset();
    repeat (5) tick();
    marker_cycle();
    run_scan("clean", 0, 0);

    // Words 1 and 3 differ from golden.
    do_reset();
    mem[1] = mem[1] ^ 32'h0000_0001;
    mem[3] = mem[3] ^ 32'h8000_0000;
    repeat (3) tick();
    marker_cycle();
    run_scan("mismatch", 2, 1);
    repeat (3) tick();
    check("fin hold done", 32'(done), 32'd1);
    check("fin hold err_count", 32'(err_count), 32'd2);

    // Clear out of FIN with fail set.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear done", 32'(done), 32'd0);
    check("clear fail", 32'(fail), 32'd0);
    check("clear err_count", 32'(err_count), 32'd0);
    check("clear first_err_idx", 32'(first_err_idx), 32'd0);
    check("clear cycle_count", 32'(cycle_count), 32'd0);
    tick();
    check("clear cycle_count+1", 32'(cycle_count), 32'd1);
    mem[1] = gold[1];
    mem[3] = gold[3];

    // Timeout: no marker for MAXC cycles.
    do_reset();
    repeat (MAXC - 1) tick();
    check("pre-tmo cycle_count", 32'(cycle_count), 32'(MAXC - 1));
    check("pre-tmo done", 32'(done), 32'd0);
    tick();
    check("tmo done", 32'(done), 32'd1);
    check("tmo timeout", 32'(timeout), 32'd1);
    check("tmo pass", 32'(pass), 32'd0);
    check("tmo fail", 32'(fail), 32'd0);
    check("tmo cycle_count", 32'(cycle_count), 32'(MAXC - 1));
    dm_we = 4'b0001; dm_addr = 16'hfffc; dm_wdata = 32'hff;
    repeat (3) tick();
    idle_bus();
    check("tmo hold timeout", 32'(timeout), 32'd1);
    check("tmo ignores marker", 32'(scan_en), 32'd0);
    check("tmo hold cycle_count", 32'(cycle_count), 32'(MAXC - 1));

    // Marker in the timeout cycle wins.
    do_reset();
    repeat (MAXC - 1) tick();
    check("race cycle_count", 32'(cycle_count), 32'(MAXC - 1));
    marker_cycle();
    check("race timeout", 32'(timeout), 32'd0);
    run_scan("race", 0, 0);

    // Reset during scan word 2, then a clean rescan.
    do_reset();
    repeat (2) tick();
    mem[2] = mem[2] ^ 32'h0000_0010;
    marker_cycle();
    tick();
    tick();
    check("abort gold_idx", 32'(gold_idx), 32'd2);
    #2 rst = 1'b1;
    #1;
    check("abort scan_en", 32'(scan_en), 32'd0);
    check("abort scan_addr", 32'(scan_addr), 32'd0);
    check("abort gold_idx 0", 32'(gold_idx), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort err_count", 32'(err_count), 32'd0);
    check("abort cycle_count", 32'(cycle_count), 32'd0);
    tick();
    rst = 1'b0;
    mem[2] = gold[2];
    repeat (2) tick();
    marker_cycle();
    run_scan("rescan", 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
